// File: rtl/msb_power_responder.sv
// msb_power_responder: always-on responder for the gated MSB half of the adder.
// Tracks the iso_en / ret_en / pse sequence from the power controller, models
// the power-switch ramp, saves/restores domain state through a retention
// shadow and reports pwr_good / iso_ok / seq_err.
// Optional feature macro: MSB_RET_PARITY_EN (even parity on the shadow).
module msb_power_responder #(
  parameter int DATA_W   = 16,
  parameter int RAMP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iso_en,
  input  logic              ret_en,
  input  logic              pse,
  input  logic [DATA_W-1:0] live_q,
  output logic [DATA_W-1:0] restore_q,
  output logic              restore_vld,
  output logic              pwr_good,
  output logic              iso_ok,
  output logic              seq_err
);

  localparam int CNT_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAMP_CYC - 1);

  typedef enum logic [2:0] {
    S_ON, S_ISO, S_SAVE, S_HOLD, S_OFF, S_RAMP, S_WAIT, S_RESTORE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shadow;
  logic [2:0]         in_s, in_d;   // {pse, ret_en, iso_en}: sampled copy, previous copy
  logic [1:0]         arm;          // edges ignored until both copies hold real samples
  logic [2:0]         rise, fall;
  logic [5:0]         edges;
  logic               multi, any_edge, par_ok;

`ifdef MSB_RET_PARITY_EN
  logic shadow_par;
  assign par_ok = ((^shadow) == shadow_par);
`else
  assign par_ok = 1'b1;
`endif

  // Two-stage input copies; an edge is the sampled copy differing from the previous one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_s <= '0;
      in_d <= '0;
      arm  <= '0;
    end else begin
      in_s <= {pse, ret_en, iso_en};
      in_d <= in_s;
      arm  <= {arm[0], 1'b1};
    end
  end

  assign rise     = arm[1] ? (in_s & ~in_d) : 3'b000;
  assign fall     = arm[1] ? (~in_s & in_d) : 3'b000;
  assign edges    = {fall, rise};
  assign any_edge = |edges;
  assign multi    = |(edges & (edges - 6'd1));   // more than one edge this cycle

  assign restore_q = shadow;

  // Sequencer FSM; outputs are registered from the current state (one cycle behind it).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_ON;
      cnt         <= '0;
      shadow      <= '0;
`ifdef MSB_RET_PARITY_EN
      shadow_par  <= 1'b0;
`endif
      restore_vld <= 1'b0;
      pwr_good    <= 1'b1;
      iso_ok      <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      iso_ok      <= (state != S_ON);
      pwr_good    <= (state != S_OFF) && (state != S_RAMP);
      restore_vld <= (state == S_RESTORE) && par_ok;
      case (state)
        S_ON: begin
          if (fall[2]) begin              // power lost without retention
            state   <= S_OFF;
            seq_err <= 1'b1;
          end else if (rise[0] && !multi) state <= S_ISO;
          else if (any_edge) seq_err <= 1'b1;
        end
        S_ISO: begin
          if (fall[2]) begin
            state   <= S_OFF;
            seq_err <= 1'b1;
          end else if (multi) seq_err <= 1'b1;
          else if (rise[1]) state <= S_SAVE;
          else if (fall[0]) state <= S_ON;
          else if (any_edge) seq_err <= 1'b1;
        end
        // Transient states always advance; a stray edge is only flagged.
        S_SAVE: begin
          shadow <= live_q;
`ifdef MSB_RET_PARITY_EN
          shadow_par <= ^live_q;
`endif
          state <= S_HOLD;
          if (any_edge) seq_err <= 1'b1;
        end
        S_HOLD: begin
          if (multi) seq_err <= 1'b1;
          else if (fall[2]) state <= S_OFF;
          else if (fall[1]) state <= S_ISO;   // retention aborted, shadow kept
          else if (any_edge) seq_err <= 1'b1;
        end
        S_OFF: begin
          if (multi) seq_err <= 1'b1;
          else if (rise[2]) begin
            state <= (RAMP_CYC == 1) ? S_WAIT : S_RAMP;
            cnt   <= CNT_LOAD;
          end else if (any_edge) seq_err <= 1'b1;
        end
        // Leave on the count that reaches zero so pwr_good lands RAMP_CYC+1 after pse.
        S_RAMP: begin
          if (fall[2] && !multi) begin
            state <= S_OFF;
            cnt   <= '0;
          end else begin
            if (any_edge) seq_err <= 1'b1;
            if (cnt <= CNT_W'(1)) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else cnt <= cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (multi) seq_err <= 1'b1;
          else if (fall[1]) state <= S_RESTORE;
          else if (any_edge) seq_err <= 1'b1;
        end
        S_RESTORE: begin
          state <= S_ISO;
          if (!par_ok || any_edge) seq_err <= 1'b1;
        end
        default: state <= S_ON;
      endcase
    end
  end

endmodule

// File: tb/tb_msb_power_responder.sv
// Randomized scoreboard bench for msb_power_responder. Scenario tasks drive the
// control sequence, push predicted restore data into a queue, and a separate
// monitor pops and compares on every restore_vld.
module tb_msb_power_responder;
  localparam int DATA_W   = 16;
  localparam int RAMP_CYC = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              iso_en = 1'b0, ret_en = 1'b0, pse = 1'b1;
  logic [DATA_W-1:0] live_q = '0;
  logic [DATA_W-1:0] restore_q;
  logic              restore_vld, pwr_good, iso_ok, seq_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_shadow;   // model: last value saved into retention

  msb_power_responder #(.DATA_W(DATA_W), .RAMP_CYC(RAMP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .iso_en(iso_en), .ret_en(ret_en), .pse(pse),
    .live_q(live_q), .restore_q(restore_q), .restore_vld(restore_vld),
    .pwr_good(pwr_good), .iso_ok(iso_ok), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return pwr_good;
      1: return iso_ok;
      default: return restore_vld;
    endcase
  endfunction

  // Cycles from the posedge that samples the last drive until sig reaches lvl; -1 on timeout.
  task automatic measure(input int sel, input logic lvl, output int lat);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (sig(sel) !== lvl && c < 40);
    lat = (sig(sel) === lvl) ? c - 1 : -1;
  endtask

  // Monitor: every restore pulse must match the oldest predicted restore.
  initial begin
    forever begin
      @(negedge clk);
      if (restore_vld === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_restore_vld", 32'(restore_q), 32'hDEAD_BEEF);
        else chk("restore_data", 32'(restore_q), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    iso_en = 1'b0; ret_en = 1'b0; pse = 1'b1; live_q = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_shadow = '0;
    idle(5);
    chk("rst_pwr_good", 32'(pwr_good), 1);
    chk("rst_iso_ok", 32'(iso_ok), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_restore_q", 32'(restore_q), 0);
    chk("rst_restore_vld", 32'(restore_vld), 0);
  endtask

  // Legal power-down, optional interrupted ramp, legal power-up with restore.
  task automatic run_legal(input logic [DATA_W-1:0] data, input bit interrupt, input bit corrupt);
    int lat;
    live_q = data;
    @(negedge clk) iso_en = 1'b1;
    idle($urandom_range(3, 6));
    chk("iso_clamp", 32'(iso_ok), 1);
    @(negedge clk) ret_en = 1'b1;
    idle(3);
    exp_shadow = data;
    chk("shadow_saved", 32'(restore_q), 32'(exp_shadow));
    live_q = ~data;
    @(negedge clk) pse = 1'b0;
    idle(10);
    chk("off_pwr_good", 32'(pwr_good), 0);
    chk("off_iso_ok", 32'(iso_ok), 1);
    if (corrupt) begin
`ifdef MSB_RET_PARITY_EN
      dut.shadow[0] = ~dut.shadow[0];
`endif
    end
    if (interrupt) begin
      @(negedge clk) pse = 1'b1;
      idle($urandom_range(1, RAMP_CYC - 1));
      pse = 1'b0;
      idle(4);
      chk("ramp_abort_pwr_good", 32'(pwr_good), 0);
    end
    @(negedge clk) pse = 1'b1;
    measure(0, 1'b1, lat);
    chk("ramp_latency", 32'(lat), RAMP_CYC + 1);
    idle($urandom_range(1, 4));
    if (!corrupt) exp_q.push_back(exp_shadow);
    @(negedge clk) ret_en = 1'b0;
    if (!corrupt) begin
      measure(2, 1'b1, lat);
      chk("restore_latency", 32'(lat), 2);
    end else begin
      idle(6);
    end
    idle(2);
    @(negedge clk) iso_en = 1'b0;
    measure(1, 1'b0, lat);
    chk("iso_release_latency", 32'(lat), 2);
    chk("cycle_seq_err", 32'(seq_err), corrupt ? 1 : 0);
    chk("cycle_pwr_good", 32'(pwr_good), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_dut();

    // Main function: fixed vector, then random data / waits / ramp interruptions.
    run_legal(16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_legal(DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    run_legal(DATA_W'($urandom), 1'b1, 1'b0);

    // Power lost in ON.
    reset_dut();
    @(negedge clk) pse = 1'b0;
    idle(3);
    chk("pse_loss_on_iso_ok", 32'(iso_ok), 1);
    chk("pse_loss_on_pwr_good", 32'(pwr_good), 0);
    chk("pse_loss_on_seq_err", 32'(seq_err), 1);

    // Power lost in ISO.
    reset_dut();
    @(negedge clk) iso_en = 1'b1;
    idle(3);
    @(negedge clk) pse = 1'b0;
    idle(3);
    chk("pse_loss_iso_pwr_good", 32'(pwr_good), 0);
    chk("pse_loss_iso_seq_err", 32'(seq_err), 1);

    // Two edges in one cycle: flagged, no transition.
    reset_dut();
    @(negedge clk) begin iso_en = 1'b1; ret_en = 1'b1; end
    idle(3);
    chk("dual_edge_seq_err", 32'(seq_err), 1);
    chk("dual_edge_pwr_good", 32'(pwr_good), 1);
    chk("dual_edge_iso_ok", 32'(iso_ok), 0);

    // Out-of-order single edge: ret_en before iso_en.
    reset_dut();
    @(negedge clk) ret_en = 1'b1;
    idle(3);
    chk("early_ret_seq_err", 32'(seq_err), 1);
    chk("early_ret_iso_ok", 32'(iso_ok), 0);

    // Retention aborted from HOLD: no restore, shadow kept.
    reset_dut();
    begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      live_q = d;
      @(negedge clk) iso_en = 1'b1;
      idle(3);
      @(negedge clk) ret_en = 1'b1;
      idle(3);
      exp_shadow = d;
      live_q = ~d;
      @(negedge clk) ret_en = 1'b0;
      idle(3);
      @(negedge clk) iso_en = 1'b0;
      idle(4);
      chk("abort_iso_ok", 32'(iso_ok), 0);
      chk("abort_seq_err", 32'(seq_err), 0);
      chk("abort_shadow_kept", 32'(restore_q), 32'(exp_shadow));
    end
    run_legal(DATA_W'($urandom), 1'b1, 1'b0);

`ifdef MSB_RET_PARITY_EN
    run_legal(DATA_W'($urandom), 1'b0, 1'b1);
`endif

    idle(5);
    chk("restore_queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
